rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter with bounded tenure. It shares one resource between four requesters and produces a registered binary owner code plus valid. The one-hot grant is the 2-to-4 decode of that code and valid, with valid acting as the decoder enable. It sits in front of shared datapath resources such as a bus or a decoder-selected register bank.

Parameters:
HOLD_MAX, 8, maximum consecutive cycles one owner keeps the grant while others are waiting; legal range 1..255.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
R  input  4  request vector; R[i] = requester i wants the resource
G  output  4  one-hot grant; G[i] = requester i owns the resource; 4'b0000 when Valid=0
Code  output  2  binary index of current owner
Valid  output  1  a grant is active

Behaviour:
- Clocking and reset:
  - One clock, Clock.
  - Reset is synchronous and active-high.
  - On a Clock edge with Reset=1: G=0000, Code=00, Valid=0, state=IDLE, ptr=0, cnt=0.
  - Reset has priority over all other activity, including mid-grant.
- Internal registers:
  - state: IDLE or OWN.
  - ptr (2 bits): highest-priority index for the next arbitration.
  - cnt: tenure counter, width ceil(log2(HOLD_MAX+1)), saturating.
- G is always decoded from Code and Valid:
  - Valid=0 -> G=0000.
  - Valid=1 -> G has only bit Code set.
- Arbitration function pick(mask):
  - Scan mask in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Return the first set index.
- IDLE state:
  - R=0000 -> stay IDLE, outputs unchanged (all zero).
  - Any R bit set -> w=pick(R). Next edge: Code=w, Valid=1, state=OWN, cnt=1, ptr=(w+1) mod 4.
  - Latency from request to grant: 1 cycle.
- OWN state, owner o=Code. Evaluate in this priority order:
  1. Release (R[o]=0):
     - If others are requesting (R & ~onehot(o) nonzero), hand off: w=pick(R & ~onehot(o)). Next edge: Code=w, Valid=1, cnt=1, ptr=(w+1) mod 4. No idle gap between owners.
     - Otherwise next edge: Valid=0, state=IDLE, Code holds, cnt=0.
  2. Preempt (R[o]=1, cnt==HOLD_MAX, others requesting): hand off exactly as in the release case.
  3. Keep (R[o]=1, all other cases):
     - Code and Valid unchanged.
     - cnt increments, saturating at HOLD_MAX.
     - A lone requester keeps the grant indefinitely.
- Non-owner request changes never affect the current grant except through rule 2.
- ptr changes only when a grant is issued, so no requester can be starved. Worst-case wait is 3*HOLD_MAX+3 cycles.
- All outputs are registered; there is no combinational path from R to G, Code or Valid.

Test Plan:
1. Reset=1 for 2 cycles with R=1111 -> G=0000, Code=00, Valid=0; after release, first grant goes to requester 0.
2. From IDLE, R=0100 at edge t -> at t+1: G=0100, Code=2, Valid=1; drop R at t+3 -> at t+4: G=0000, Valid=0.
3. HOLD_MAX=4, R=1111 held -> grant sequence 0,1,2,3,0, each owner for exactly 4 cycles, with no gap cycles.
4. Owner 1 granted, R changes from 0010 to 1001 in one cycle -> next edge G=1000 (requester 3, first at or after ptr=2), Valid stays 1 throughout.
5. HOLD_MAX=2, R=0001 held for 10 cycles -> G=0001 for all 10 cycles, cnt saturates at 2, no preemption.
6. Owner 2 mid-tenure, Reset pulsed for 1 cycle -> next edge G=0000, Valid=0; with R=1111 afterward, the next grant goes to requester 0 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with bounded tenure.
//
// Shares one resource between four requesters. The owner is held as a registered
// binary code plus a valid flag. The one-hot grant is the 2-to-4 decode of that
// code, with Valid acting as the decoder enable. If an owner keeps requesting for
// HOLD_MAX consecutive cycles while others are waiting, the grant is taken away.
//
// Parameters:
//   HOLD_MAX - maximum consecutive cycles one owner may hold the grant while
//              others are waiting (1..255)
//
// Ports:
//   Clock  - rising-edge clock
//   Reset  - synchronous, active-high reset
//   R      - request vector, R[i] = requester i wants the resource
//   G      - one-hot grant, all zero when Valid is low
//   Code   - binary index of the current owner
//   Valid  - a grant is active
module rr_arbiter4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] R,
    output logic [3:0] G,
    output logic [1:0] Code,
    output logic       Valid
);

    localparam int unsigned CntW = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        StIdle,
        StOwn
    } state_e;

    state_e          state_q;
    logic [1:0]      ptr_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      code_q;
    logic            valid_q;

    logic [3:0]      others;
    logic [3:0]      req_mask;
    logic [1:0]      win;
    logic            at_max;
    logic            own_req;

    // First set bit of mask scanning base, base+1, base+2, base+3 (mod 4).
    // Scanning from the far end lets the closest hit overwrite the result.
    function automatic logic [1:0] pick(input logic [3:0] mask, input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] res;
        res = base;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k);
            if (mask[idx]) begin
                res = idx;
            end
        end
        return res;
    endfunction

    always_comb begin
        others   = R & ~(4'b0001 << code_q);
        own_req  = R[code_q];
        // In IDLE every requester competes; while owning, only the others do.
        req_mask = (state_q == StIdle) ? R : others;
        win      = pick(req_mask, ptr_q);
        at_max   = (cnt_q == CntW'(HOLD_MAX));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|R) begin
                        state_q <= StOwn;
                        code_q  <= win;
                        valid_q <= 1'b1;
                        cnt_q   <= CntW'(1);
                        ptr_q   <= win + 2'd1;
                    end
                end
                StOwn: begin
                    if ((!own_req || at_max) && (|others)) begin
                        // Release or preempt with someone waiting: hand off, no gap.
                        code_q  <= win;
                        valid_q <= 1'b1;
                        cnt_q   <= CntW'(1);
                        ptr_q   <= win + 2'd1;
                    end else if (!own_req) begin
                        // Code deliberately holds its last value while idle.
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                    end else if (!at_max) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        G = 4'b0000;
        if (valid_q) begin
            G[code_q] = 1'b1;
        end
    end

    assign Code  = code_q;
    assign Valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] R     = 4'b0000;

    logic [3:0] g4, g2;
    logic [1:0] c4, c2;
    logic       v4, v2;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.HOLD_MAX(4)) dut4 (
        .Clock (Clock),
        .Reset (Reset),
        .R     (R),
        .G     (g4),
        .Code  (c4),
        .Valid (v4)
    );

    rr_arbiter4 #(.HOLD_MAX(2)) dut2 (
        .Clock (Clock),
        .Reset (Reset),
        .R     (R),
        .G     (g2),
        .Code  (c2),
        .Valid (v2)
    );

    always #5 Clock = ~Clock;

    // Reference model: one slot per DUT instance (0: HOLD_MAX=4, 1: HOLD_MAX=2).
    int hold [2] = '{4, 2};
    int m_valid [2];
    int m_code [2];
    int m_ptr [2];
    int m_cnt [2];
    bit m_armed = 1'b0;

    function automatic int pick(input int mask, input int base);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (base + k) % 4;
            if (((mask >> idx) & 1) == 1) return idx;
        end
        return -1;
    endfunction

    function automatic int exp_g(input int i);
        return (m_valid[i] != 0) ? (1 << m_code[i]) : 0;
    endfunction

    always @(posedge Clock) begin
        int r;
        r = int'(R);
        if (Reset) m_armed <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            int o, own, others, w;
            if (Reset) begin
                m_valid[i] <= 0;
                m_code[i]  <= 0;
                m_ptr[i]   <= 0;
                m_cnt[i]   <= 0;
            end else if (m_valid[i] == 0) begin
                if (r != 0) begin
                    w = pick(r, m_ptr[i]);
                    m_valid[i] <= 1;
                    m_code[i]  <= w;
                    m_cnt[i]   <= 1;
                    m_ptr[i]   <= (w + 1) % 4;
                end
            end else begin
                o      = m_code[i];
                own    = (r >> o) & 1;
                others = r & ~(1 << o) & 15;
                if ((own == 0 || m_cnt[i] == hold[i]) && others != 0) begin
                    w = pick(others, m_ptr[i]);
                    m_code[i] <= w;
                    m_cnt[i]  <= 1;
                    m_ptr[i]  <= (w + 1) % 4;
                end else if (own == 0) begin
                    m_valid[i] <= 0;
                    m_cnt[i]   <= 0;
                end else if (m_cnt[i] < hold[i]) begin
                    m_cnt[i] <= m_cnt[i] + 1;
                end
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [3:0] g, input logic [1:0] c, input logic v);
        checks++;
        if (g !== 4'(exp_g(i)) || v !== 1'(m_valid[i]) || c !== 2'(m_code[i])) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t: G=%b Code=%0d Valid=%b, required G=%b Code=%0d Valid=%0d",
                     i, $time, g, c, v, 4'(exp_g(i)), m_code[i], m_valid[i]);
        end
    endtask

    always @(negedge Clock) begin
        if (m_armed) begin
            cmp_inst(0, g4, c4, v4);
            cmp_inst(1, g2, c2, v2);
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, act, req);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    logic [3:0] vec [24] = '{
        4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010,
        4'b0110, 4'b0000, 4'b1111, 4'b1111, 4'b0011, 4'b0101,
        4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b0001, 4'b0111,
        4'b0111, 4'b0111, 4'b0111, 4'b0010, 4'b1001, 4'b0000
    };

    initial begin
        // 1: reset with all requests up, then first grant goes to 0.
        Reset = 1'b1;
        R     = 4'b1111;
        tick();
        tick();
        check("reset_g", int'(g4), 0);
        check("reset_code", int'(c4), 0);
        check("reset_valid", int'(v4), 0);
        Reset = 1'b0;

        // 3: HOLD_MAX=4 with all requesting rotates 0,1,2,3,0 every 4 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("rotate_%0d", i), int'(g4), 1 << ((i / 4) % 4));
            if (i == 0) check("first_grant_dut2", int'(g2), 1);
            check($sformatf("rotate_valid_%0d", i), int'(v4), 1);
        end

        // 2: request 2 from idle, one-cycle latency, drop releases.
        R = 4'b0000;
        tick();
        check("idle_valid", int'(v4), 0);
        check("idle_g", int'(g4), 0);
        R = 4'b0100;
        tick();
        check("req2_g", int'(g4), 4'b0100);
        check("req2_code", int'(c4), 2);
        check("req2_valid", int'(v4), 1);
        tick();
        tick();
        check("req2_hold_g", int'(g4), 4'b0100);
        R = 4'b0000;
        tick();
        check("drop_g", int'(g4), 0);
        check("drop_valid", int'(v4), 0);

        // 4: owner 1, then R jumps to 1001: requester 3 wins from ptr=2.
        R = 4'b0010;
        tick();
        check("own1_g", int'(g4), 4'b0010);
        R = 4'b1001;
        tick();
        check("handoff_g", int'(g4), 4'b1000);
        check("handoff_valid", int'(v4), 1);

        // 5: lone requester on HOLD_MAX=2 is never preempted.
        R = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("lone_%0d", i), int'(g2), 4'b0001);
        end

        // 6: reset mid-tenure of owner 2 restores ptr to 0.
        R = 4'b0100;
        tick();
        check("own2_g", int'(g4), 4'b0100);
        tick();
        check("own2_mid_g", int'(g4), 4'b0100);
        Reset = 1'b1;
        R     = 4'b1111;
        tick();
        check("midreset_g", int'(g4), 0);
        check("midreset_valid", int'(v4), 0);
        check("midreset_code", int'(c4), 0);
        Reset = 1'b0;
        tick();
        check("postreset_g", int'(g4), 4'b0001);
        check("postreset_g_dut2", int'(g2), 4'b0001);

        // Mixed directed vectors, each held two cycles, checked by the model.
        for (int i = 0; i < 24; i++) begin
            R = vec[i];
            tick();
            tick();
        end
        R = 4'b0000;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
